// File: rtl/bpm_position_calc_if.sv
// Handshake bus between the position calculator and one floating-point core
// (add/sub, divide or multiply). The calculator is the master: it presents
// operands with a one-cycle nd strobe and waits for the rdy pulse with the result.
interface bpm_position_calc_if #(
   parameter int SF_WIDTH = 32
);
   logic [SF_WIDTH-1:0] a;
   logic [SF_WIDTH-1:0] b;
   logic [5:0]          operation;
   logic                nd;
   logic                rfd;
   logic                rdy;
   logic [SF_WIDTH-1:0] result;

   modport master (
      output a, b, operation, nd,
      input  rfd, rdy, result
   );

   modport slave (
      input  a, b, operation, nd,
      output rfd, rdy, result
   );
endinterface

// File: rtl/bpm_position_calc.sv
// Beam position by difference-over-sum on four compensated channel powers:
//   X = Kx*(A-C)/(A+C), Y = Ky*(B-D)/(B+D), Sum = (A+C)+(B+D).
// The arithmetic runs as a strict sequence of single-precision operations on
// three external cores (add/sub, div, mul); only one operation is ever
// outstanding. Each operation is an ISSUE state (wait for rfd, pulse nd) and a
// WAIT state (wait for rdy, bounded by a timeout). A zero denominator skips
// the divide/multiply for that axis and forces its result to +0.
module bpm_position_calc #(
   parameter int SF_WIDTH    = 32,
   parameter int TIMEOUT_CYC = 255,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_din_valid,
   input  logic [SF_WIDTH-1:0]  i_cha_power,
   input  logic [SF_WIDTH-1:0]  i_chb_power,
   input  logic [SF_WIDTH-1:0]  i_chc_power,
   input  logic [SF_WIDTH-1:0]  i_chd_power,
   input  logic [SF_WIDTH-1:0]  i_kx,
   input  logic [SF_WIDTH-1:0]  i_ky,
   output logic [SF_WIDTH-1:0]  o_x_pos,
   output logic [SF_WIDTH-1:0]  o_y_pos,
   output logic [SF_WIDTH-1:0]  o_sum_out,
   output logic                 o_pos_valid,
   output logic                 o_busy,
   output logic                 o_div0_x,
   output logic                 o_div0_y,
   output logic                 o_timeout_err,
   output logic [CNT_WIDTH-1:0] o_overrun_cnt,
   bpm_position_calc_if.master  addsub_bus,
   bpm_position_calc_if.master  div_bus,
   bpm_position_calc_if.master  mul_bus
);

   localparam int                  TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [TMO_W-1:0]    TMO_ONE  = TMO_W'(1);
   localparam logic [TMO_W-1:0]    TMO_ZERO = TMO_W'(0);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [5:0]          OP_ADD   = 6'b000000;
   localparam logic [5:0]          OP_SUB   = 6'b000001;
   localparam logic [SF_WIDTH-1:0] F_ZERO   = {SF_WIDTH{1'b0}};

   typedef enum logic [4:0] {
      S_IDLE,
      S_ADD_AC_I,  S_ADD_AC_W,
      S_SUB_AC_I,  S_SUB_AC_W,
      S_ADD_BD_I,  S_ADD_BD_W,
      S_SUB_BD_I,  S_SUB_BD_W,
      S_DIV_X_I,   S_DIV_X_W,
      S_DIV_Y_I,   S_DIV_Y_W,
      S_MUL_X_I,   S_MUL_X_W,
      S_MUL_Y_I,   S_MUL_Y_W,
      S_ADD_SUM_I, S_ADD_SUM_W,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Captured inputs and intermediate results
   logic [SF_WIDTH-1:0]  r_a, r_b, r_c, r_d, r_kx, r_ky;
   logic [SF_WIDTH-1:0]  r_sum_ac, r_dif_ac, r_sum_bd, r_dif_bd;
   logic [SF_WIDTH-1:0]  r_q_x, r_q_y, r_x, r_y, r_sum;
   logic                 r_zx, r_zy;
   logic [TMO_W-1:0]     r_tmo_cnt;

   // Output registers
   logic [SF_WIDTH-1:0]  r_x_pos, r_y_pos, r_sum_out;
   logic                 r_pos_valid, r_busy, r_div0_x, r_div0_y, r_timeout_err;
   logic [CNT_WIDTH-1:0] r_overrun_cnt;

   // Core drive and FSM side signals
   logic                 w_as_nd, w_dv_nd, w_ml_nd;
   logic [5:0]           w_as_op;
   logic [SF_WIDTH-1:0]  w_as_a, w_as_b, w_dv_a, w_dv_b, w_ml_a, w_ml_b;
   logic                 w_in_wait, w_rdy_sel, w_enter_wait;
   logic                 w_tmo_hit, w_abort, w_accept;

   // A WAIT state advances on rdy, aborts when the timeout is reached, else holds.
   function automatic state_t wait_next(input logic rdy, input logic hit,
                                        input state_t cur, input state_t nxt);
      state_t s;
      if (rdy) begin
         s = nxt;
      end else if (hit) begin
         s = S_IDLE;
      end else begin
         s = cur;
      end
      return s;
   endfunction

   // An encoding with all exponent and mantissa bits clear is +0 or -0.
   function automatic logic is_fzero(input logic [SF_WIDTH-1:0] f);
      return (f[SF_WIDTH-2:0] == {(SF_WIDTH-1){1'b0}});
   endfunction

   assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
   assign w_abort   = w_in_wait & ~w_rdy_sel & w_tmo_hit;
   assign w_accept  = (r_state == S_IDLE) & i_din_valid;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and core operand/strobe selection
   always_comb begin
      w_state_nxt  = r_state;
      w_as_nd      = 1'b0;
      w_as_op      = OP_ADD;
      w_as_a       = F_ZERO;
      w_as_b       = F_ZERO;
      w_dv_nd      = 1'b0;
      w_dv_a       = F_ZERO;
      w_dv_b       = F_ZERO;
      w_ml_nd      = 1'b0;
      w_ml_a       = F_ZERO;
      w_ml_b       = F_ZERO;
      w_in_wait    = 1'b0;
      w_rdy_sel    = 1'b0;
      w_enter_wait = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_din_valid) begin
               w_state_nxt = S_ADD_AC_I;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ADD_AC_I, S_SUB_AC_I, S_ADD_BD_I, S_SUB_BD_I, S_ADD_SUM_I: begin
            case (r_state)
               S_ADD_AC_I: begin w_as_a = r_a;      w_as_b = r_c;      w_as_op = OP_ADD; end
               S_SUB_AC_I: begin w_as_a = r_a;      w_as_b = r_c;      w_as_op = OP_SUB; end
               S_ADD_BD_I: begin w_as_a = r_b;      w_as_b = r_d;      w_as_op = OP_ADD; end
               S_SUB_BD_I: begin w_as_a = r_b;      w_as_b = r_d;      w_as_op = OP_SUB; end
               default:    begin w_as_a = r_sum_ac; w_as_b = r_sum_bd; w_as_op = OP_ADD; end
            endcase
            if (addsub_bus.rfd) begin
               w_as_nd      = 1'b1;
               w_enter_wait = 1'b1;
               w_state_nxt  = state_t'(r_state + 5'd1);
            end else begin
               w_state_nxt  = r_state;
            end
         end
         S_DIV_X_I, S_DIV_Y_I: begin
            if (r_state == S_DIV_X_I) begin
               w_dv_a = r_dif_ac;
               w_dv_b = r_sum_ac;
            end else begin
               w_dv_a = r_dif_bd;
               w_dv_b = r_sum_bd;
            end
            if (div_bus.rfd) begin
               w_dv_nd      = 1'b1;
               w_enter_wait = 1'b1;
               w_state_nxt  = state_t'(r_state + 5'd1);
            end else begin
               w_state_nxt  = r_state;
            end
         end
         S_MUL_X_I, S_MUL_Y_I: begin
            if (r_state == S_MUL_X_I) begin
               w_ml_a = r_q_x;
               w_ml_b = r_kx;
            end else begin
               w_ml_a = r_q_y;
               w_ml_b = r_ky;
            end
            if (mul_bus.rfd) begin
               w_ml_nd      = 1'b1;
               w_enter_wait = 1'b1;
               w_state_nxt  = state_t'(r_state + 5'd1);
            end else begin
               w_state_nxt  = r_state;
            end
         end
         S_ADD_AC_W: begin
            w_in_wait   = 1'b1;
            w_rdy_sel   = addsub_bus.rdy;
            w_state_nxt = wait_next(w_rdy_sel, w_tmo_hit, r_state, S_SUB_AC_I);
         end
         S_SUB_AC_W: begin
            w_in_wait   = 1'b1;
            w_rdy_sel   = addsub_bus.rdy;
            w_state_nxt = wait_next(w_rdy_sel, w_tmo_hit, r_state, S_ADD_BD_I);
         end
         S_ADD_BD_W: begin
            w_in_wait   = 1'b1;
            w_rdy_sel   = addsub_bus.rdy;
            w_state_nxt = wait_next(w_rdy_sel, w_tmo_hit, r_state, S_SUB_BD_I);
         end
         S_SUB_BD_W: begin
            w_in_wait   = 1'b1;
            w_rdy_sel   = addsub_bus.rdy;
            w_state_nxt = wait_next(w_rdy_sel, w_tmo_hit, r_state,
                                    r_zx ? (r_zy ? S_ADD_SUM_I : S_DIV_Y_I) : S_DIV_X_I);
         end
         S_DIV_X_W: begin
            w_in_wait   = 1'b1;
            w_rdy_sel   = div_bus.rdy;
            w_state_nxt = wait_next(w_rdy_sel, w_tmo_hit, r_state,
                                    r_zy ? S_MUL_X_I : S_DIV_Y_I);
         end
         S_DIV_Y_W: begin
            w_in_wait   = 1'b1;
            w_rdy_sel   = div_bus.rdy;
            w_state_nxt = wait_next(w_rdy_sel, w_tmo_hit, r_state,
                                    r_zx ? S_MUL_Y_I : S_MUL_X_I);
         end
         S_MUL_X_W: begin
            w_in_wait   = 1'b1;
            w_rdy_sel   = mul_bus.rdy;
            w_state_nxt = wait_next(w_rdy_sel, w_tmo_hit, r_state,
                                    r_zy ? S_ADD_SUM_I : S_MUL_Y_I);
         end
         S_MUL_Y_W: begin
            w_in_wait   = 1'b1;
            w_rdy_sel   = mul_bus.rdy;
            w_state_nxt = wait_next(w_rdy_sel, w_tmo_hit, r_state, S_ADD_SUM_I);
         end
         S_ADD_SUM_W: begin
            w_in_wait   = 1'b1;
            w_rdy_sel   = addsub_bus.rdy;
            w_state_nxt = wait_next(w_rdy_sel, w_tmo_hit, r_state, S_DONE);
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign addsub_bus.nd        = w_as_nd;
   assign addsub_bus.operation = w_as_op;
   assign addsub_bus.a         = w_as_a;
   assign addsub_bus.b         = w_as_b;
   assign div_bus.nd           = w_dv_nd;
   assign div_bus.operation    = OP_ADD;
   assign div_bus.a            = w_dv_a;
   assign div_bus.b            = w_dv_b;
   assign mul_bus.nd           = w_ml_nd;
   assign mul_bus.operation    = OP_ADD;
   assign mul_bus.a            = w_ml_a;
   assign mul_bus.b            = w_ml_b;

   // Per-operation timeout: restarts on every WAIT entry, counts while waiting
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo_cnt <= TMO_ZERO;
      end else if (w_enter_wait) begin
         r_tmo_cnt <= TMO_ZERO;
      end else if (w_in_wait) begin
         r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
      end
   end

   // Input capture, intermediate results and the all-at-once output update
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a <= F_ZERO;  r_b <= F_ZERO;  r_c <= F_ZERO;  r_d <= F_ZERO;
         r_kx <= F_ZERO; r_ky <= F_ZERO;
         r_sum_ac <= F_ZERO; r_dif_ac <= F_ZERO; r_sum_bd <= F_ZERO; r_dif_bd <= F_ZERO;
         r_q_x <= F_ZERO; r_q_y <= F_ZERO; r_x <= F_ZERO; r_y <= F_ZERO; r_sum <= F_ZERO;
         r_zx <= 1'b0; r_zy <= 1'b0;
         r_x_pos <= F_ZERO; r_y_pos <= F_ZERO; r_sum_out <= F_ZERO;
         r_pos_valid <= 1'b0; r_busy <= 1'b0;
         r_div0_x <= 1'b0; r_div0_y <= 1'b0; r_timeout_err <= 1'b0;
         r_overrun_cnt <= {CNT_WIDTH{1'b0}};
      end else begin
         r_pos_valid <= 1'b0;
         if (w_accept) begin
            r_a    <= i_cha_power;
            r_b    <= i_chb_power;
            r_c    <= i_chc_power;
            r_d    <= i_chd_power;
            r_kx   <= i_kx;
            r_ky   <= i_ky;
            r_busy <= 1'b1;
         end
         // busy still reads 1 in the DONE cycle, so a pulse there is dropped too
         if (i_din_valid && r_busy && (r_overrun_cnt != CNT_MAX)) begin
            r_overrun_cnt <= r_overrun_cnt + CNT_ONE;
         end
         if (w_in_wait && w_rdy_sel) begin
            case (r_state)
               S_ADD_AC_W: begin
                  r_sum_ac <= addsub_bus.result;
                  r_zx     <= is_fzero(addsub_bus.result);
               end
               S_SUB_AC_W: r_dif_ac <= addsub_bus.result;
               S_ADD_BD_W: begin
                  r_sum_bd <= addsub_bus.result;
                  r_zy     <= is_fzero(addsub_bus.result);
               end
               S_SUB_BD_W:  r_dif_bd <= addsub_bus.result;
               S_DIV_X_W:   r_q_x    <= div_bus.result;
               S_DIV_Y_W:   r_q_y    <= div_bus.result;
               S_MUL_X_W:   r_x      <= mul_bus.result;
               S_MUL_Y_W:   r_y      <= mul_bus.result;
               S_ADD_SUM_W: r_sum    <= addsub_bus.result;
               default:     r_sum    <= r_sum;
            endcase
         end
         if (r_state == S_DONE) begin
            r_x_pos     <= r_zx ? F_ZERO : r_x;
            r_y_pos     <= r_zy ? F_ZERO : r_y;
            r_sum_out   <= r_sum;
            r_div0_x    <= r_zx;
            r_div0_y    <= r_zy;
            r_pos_valid <= 1'b1;
            r_busy      <= 1'b0;
         end
         if (w_abort) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
         end
      end
   end

   assign o_x_pos       = r_x_pos;
   assign o_y_pos       = r_y_pos;
   assign o_sum_out     = r_sum_out;
   assign o_pos_valid   = r_pos_valid;
   assign o_busy        = r_busy;
   assign o_div0_x      = r_div0_x;
   assign o_div0_y      = r_div0_y;
   assign o_timeout_err = r_timeout_err;
   assign o_overrun_cnt = r_overrun_cnt;

endmodule
